// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state encoding, defaults and
// a constant clog2 helper used to size counters.
package pong_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StPlay  = 2'd2,
        StOver  = 2'd3
    } state_e;

    localparam int unsigned DefaultScoreLimit = 11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/score_channel.sv
// One player's score: rising-edge miss detector feeding a saturating counter with a
// synchronous zero. Exposes the next-state score so the top can judge wins same clock.
module score_channel
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   point_i,
    input  logic                   count_en_i,
    input  logic                   zero_i,
    output logic                   event_o,
    output logic [SCORE_WIDTH-1:0] score_o,
    output logic [SCORE_WIDTH-1:0] score_next_o
);

    logic                   point_q;
    logic [SCORE_WIDTH-1:0] score_q;
    logic [SCORE_WIDTH-1:0] score_d;

    assign event_o = point_i & ~point_q;

    always_comb begin
        score_d = score_q;
        if (zero_i) begin
            score_d = '0;
        end else if (count_en_i && event_o && (score_q != '1)) begin
            score_d = score_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            point_q <= 1'b0;
            score_q <= '0;
        end else begin
            point_q <= point_i;
            score_q <= score_d;
        end
    end

    assign score_o      = score_q;
    assign score_next_o = score_d;

endmodule

// File: rtl/score_keeper.sv
// Match controller for multiplayer pong: IDLE/SERVE/PLAY/OVER sequencing, serve pause,
// per-channel ball reset requests and winner selection with optional win-by-two.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned SCORE_WIDTH  = 8,
    parameter int unsigned SCORE_LIMIT  = DefaultScoreLimit,
    parameter int unsigned WIN_BY_TWO   = 0,
    parameter int unsigned SERVE_DELAY  = 60,
    parameter int unsigned WINNER_WIDTH = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic                               tick_i,
    input  logic                               start_i,
    input  logic                               clear_i,
    input  logic [NUM_PLAYERS-1:0]             point_i,
    output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] score_o,
    output logic [NUM_PLAYERS-1:0]             ball_reset_o,
    output logic                               play_enable_o,
    output logic                               game_over_o,
    output logic [WINNER_WIDTH-1:0]            winner_o,
    output logic [1:0]                         state_o
);

    localparam int unsigned CntWidth = clog2(SERVE_DELAY + 1);
    localparam logic [CntWidth-1:0]    ServeLoad = CntWidth'(SERVE_DELAY);
    localparam logic [SCORE_WIDTH-1:0] Limit     = SCORE_WIDTH'(SCORE_LIMIT);

    state_e                  state_q, state_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [WINNER_WIDTH-1:0] winner_q, winner_d;
    logic [NUM_PLAYERS-1:0]  ball_reset_q, ball_reset_d;

    logic                    in_play;
    logic                    zero_scores;
    logic [NUM_PLAYERS-1:0]  edge_raw;
    logic [NUM_PLAYERS-1:0]  events;
    logic [SCORE_WIDTH-1:0]  score_next [NUM_PLAYERS];
    logic                    win_any;
    logic [WINNER_WIDTH-1:0] win_idx;

    assign in_play = (state_q == StPlay);
    assign events  = edge_raw & {NUM_PLAYERS{in_play}};

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
        score_channel #(
            .SCORE_WIDTH (SCORE_WIDTH)
        ) u_chan (
            .clock_i      (clock_i),
            .reset_ni     (reset_ni),
            .point_i      (point_i[i]),
            .count_en_i   (in_play),
            .zero_i       (zero_scores),
            .event_o      (edge_raw[i]),
            .score_o      (score_o[i*SCORE_WIDTH +: SCORE_WIDTH]),
            .score_next_o (score_next[i])
        );
    end

    // Scan from the top so the lowest qualifying index is the one left standing.
    always_comb begin
        logic [SCORE_WIDTH-1:0] max_other;
        logic                   qualifies;
        win_any   = 1'b0;
        win_idx   = '0;
        max_other = '0;
        qualifies = 1'b0;
        for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
            max_other = '0;
            for (int j = 0; j < int'(NUM_PLAYERS); j++) begin
                if ((j != i) && (score_next[j] > max_other)) begin
                    max_other = score_next[j];
                end
            end
            qualifies = (score_next[i] >= Limit) &&
                        ((WIN_BY_TWO == 0) ||
                         ({1'b0, score_next[i]} >= ({1'b0, max_other} + (SCORE_WIDTH+1)'(2))));
            if (qualifies) begin
                win_any = 1'b1;
                win_idx = WINNER_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        winner_d     = winner_q;
        ball_reset_d = ball_reset_q;
        zero_scores  = 1'b0;
        if (clear_i) begin
            state_d      = StIdle;
            cnt_d        = '0;
            winner_d     = '0;
            ball_reset_d = '1;
            zero_scores  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StOver: begin
                    ball_reset_d = '1;
                    if (start_i) begin
                        state_d     = StServe;
                        cnt_d       = ServeLoad;
                        zero_scores = 1'b1;
                    end
                end
                StServe: begin
                    if (tick_i) begin
                        if (cnt_q == CntWidth'(1)) begin
                            state_d      = StPlay;
                            ball_reset_d = '0;
                        end
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StPlay: begin
                    if (|events) begin
                        if (win_any) begin
                            state_d      = StOver;
                            winner_d     = win_idx;
                            ball_reset_d = '1;
                        end else begin
                            state_d      = StServe;
                            cnt_d        = ServeLoad;
                            ball_reset_d = events;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            winner_q     <= '0;
            ball_reset_q <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            winner_q     <= winner_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    assign ball_reset_o  = ball_reset_q;
    assign play_enable_o = (state_q == StPlay);
    assign game_over_o   = (state_q == StOver);
    assign winner_o      = winner_q;
    assign state_o       = state_q;

endmodule
